grasshopper_key_expand: RTL and testbench
=========================================

// Module: grasshopper_key_expand
// PURPOSE
// - Kuznyechik (GOST R 34.12-2015) key schedule; the stage directly upstream of grasshopper.
// - Takes a 256-bit master key on a one-cycle req_i pulse.
// - Produces round keys K1..K10 via 32 Feistel iterations with constants C_i = L(Vec128(i)).
// - Keys sit in a 10x128 register file; grasshopper reads them by index.
// PARAMETERS
// - NUM_RK  10  number of round keys stored; fixed by the standard, not to be overridden.
// PORTS
// - clk_i      in   1    clock; all state on rising edge.
// - rst_i      in   1    asynchronous, active-low reset.
// - req_i      in   1    start pulse; key_i sampled on the same edge.
// - key_i      in   256  master key; [255:128]=K1, [127:0]=K2.
// - busy_o     out  1    expansion in progress.
// - ready_o    out  1    all NUM_RK keys valid; held until next accepted req_i or reset.
// - rk_addr_i  in   4    round-key index 0..9 (0=K1).
// - rk_o       out  128  combinational read of rk[rk_addr_i]; 0 when rk_addr_i>9.
// BEHAVIOUR
// - Reset (rst_i=0, async):
//   - FSM=IDLE; busy_o=0; ready_o=0; iteration counter=0.
//   - All rk regs and Feistel regs a1/a0 = 0, so rk_o=0.
// - Transforms; byte 15 = bits [127:120]:
//   - S: byte-wise pi table.
//   - R: a -> {l(a), a[127:8]}.
//   - l: GF(2^8) sum, poly 0x1C3, coefficients a15..a0 = 148,32,133,16,194,192,1,251,1,192,194,16,133,32,148,1.
//   - L = R^16.
// - Constants: 32-entry localparam table C_1..C_32; C_1 = 6ea276726c487ab85d27bd10dd849401.
// - FSM: IDLE -> LOAD -> SX -> LIN -> (SX | DONE) -> IDLE-equivalent DONE.
//   - IDLE/DONE: req_i=1 -> LOAD.
//     - a1<=key_i[255:128], a0<=key_i[127:0].
//     - rk[0]<=a1 value, rk[1]<=a0 value.
//     - ready_o<=0, busy_o<=1, i<=1.
//   - SX: t <= S(a1 ^ C_i); 1 cycle.
//   - LIN: apply R to t once per cycle, 16 cycles (see CONFIGURATION).
//     - Final LIN cycle: a1 <= L(..)^a0, a0 <= a1, i<=i+1.
//     - If i%8==0: rk[i/4] <= new a1, rk[i/4+1] <= new a0.
//     - Then: if i==32 -> DONE with busy_o<=0, ready_o<=1; else -> SX.
// - Latency:
//   - Accepting edge E; ready_o rises after edge E+1+32*(1+LC).
//   - LC=16 -> E+545; LC=1 -> E+65.
//   - busy_o high from edge E to the edge ready_o rises, exclusive.
// - Handshake and boundary conditions:
//   - req_i while busy_o=1 ignored; key_i is not re-sampled.
//   - req_i in DONE restarts: ready_o drops on the accepting edge; old keys are overwritten progressively.
//   - rk_o during busy_o=1 undefined for consumers; bench may check partial keys only at documented write points.
//   - Reset mid-expansion aborts immediately: all regs cleared, ready_o stays 0 until a full new run.
//   - key_i changes after the accepting edge have no effect.
// CONFIGURATION
// - GH_KS_UNROLL_EN defined:
//   - LIN performs the full L (16 R stages unrolled combinationally) in 1 cycle; LC=1.
// - GH_KS_UNROLL_EN undefined (default):
//   - single R stage reused 16 times with a 4-bit sub-counter; LC=16.
//   - Smaller area, identical results.
// TESTING
// - Standard vector:
//   - key 8899aabbccddeeff0011223344556677_fedcba98765432100123456789abcdef.
//   - K1=8899aabbccddeeff0011223344556677; K2=fedcba98765432100123456789abcdef.
//   - K3=db31485315694343228d6aef8cc78c44; K4=3d4553d8e9cfec6815ebadc40a9ffd04.
//   - K10=72e9dd7416bcf45b755dbaa88e4a4043.
// - Latency: req_i at edge E -> ready_o first high after E+545 (E+65 with GH_KS_UNROLL_EN); busy_o=1 exactly in between.
// - Busy req: second req_i with key all-0 at E+100 -> ignored, final keys still match the standard vector.
// - Mid-run reset: rst_i=0 at E+200 -> busy_o=0, ready_o=0, rk_o=0 for all addr; new req -> correct keys.
// - Restart from DONE: req with key all-0 -> ready_o drops next edge; completes with K1=K2=0, K3 from schedule.
// - Address bound: rk_addr_i=10..15 -> rk_o=0 in all states.

Source files
------------

// File: rtl/grasshopper_key_expand.sv
// Kuznyechik (GOST R 34.12-2015) key schedule: 256-bit master key -> ten 128-bit round keys.
// Define GH_KS_UNROLL_EN for a single-cycle L transform; default reuses one R stage for 16 cycles.
module grasshopper_key_expand (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_i,
  input  logic [255:0] key_i,
  output logic         busy_o,
  output logic         ready_o,
  input  logic [3:0]   rk_addr_i,
  output logic [127:0] rk_o
);

  // Fixed by the standard; deliberately not a parameter.
  localparam int NUM_RK   = 10;
  localparam int NUM_ITER = 32;

  typedef enum logic [2:0] {IDLE, LOAD, SX, LIN, DONE} state_e;

  localparam logic [7:0] PI [256] = '{
    8'd252, 8'd238, 8'd221, 8'd17,  8'd207, 8'd110, 8'd49,  8'd22,  8'd251, 8'd196, 8'd250, 8'd218, 8'd35,  8'd197, 8'd4,   8'd77,
    8'd233, 8'd119, 8'd240, 8'd219, 8'd147, 8'd46,  8'd153, 8'd186, 8'd23,  8'd54,  8'd241, 8'd187, 8'd20,  8'd205, 8'd95,  8'd193,
    8'd249, 8'd24,  8'd101, 8'd90,  8'd226, 8'd92,  8'd239, 8'd33,  8'd129, 8'd28,  8'd60,  8'd66,  8'd139, 8'd1,   8'd142, 8'd79,
    8'd5,   8'd132, 8'd2,   8'd174, 8'd227, 8'd106, 8'd143, 8'd160, 8'd6,   8'd11,  8'd237, 8'd152, 8'd127, 8'd212, 8'd211, 8'd31,
    8'd235, 8'd52,  8'd44,  8'd81,  8'd234, 8'd200, 8'd72,  8'd171, 8'd242, 8'd42,  8'd104, 8'd162, 8'd253, 8'd58,  8'd206, 8'd204,
    8'd181, 8'd112, 8'd14,  8'd86,  8'd8,   8'd12,  8'd118, 8'd18,  8'd191, 8'd114, 8'd19,  8'd71,  8'd156, 8'd183, 8'd93,  8'd135,
    8'd21,  8'd161, 8'd150, 8'd41,  8'd16,  8'd123, 8'd154, 8'd199, 8'd243, 8'd145, 8'd120, 8'd111, 8'd157, 8'd158, 8'd178, 8'd177,
    8'd50,  8'd117, 8'd25,  8'd61,  8'd255, 8'd53,  8'd138, 8'd126, 8'd109, 8'd84,  8'd198, 8'd128, 8'd195, 8'd189, 8'd13,  8'd87,
    8'd223, 8'd245, 8'd36,  8'd169, 8'd62,  8'd168, 8'd67,  8'd201, 8'd215, 8'd121, 8'd214, 8'd246, 8'd124, 8'd34,  8'd185, 8'd3,
    8'd224, 8'd15,  8'd236, 8'd222, 8'd122, 8'd148, 8'd176, 8'd188, 8'd220, 8'd232, 8'd40,  8'd80,  8'd78,  8'd51,  8'd10,  8'd74,
    8'd167, 8'd151, 8'd96,  8'd115, 8'd30,  8'd0,   8'd98,  8'd68,  8'd26,  8'd184, 8'd56,  8'd130, 8'd100, 8'd159, 8'd38,  8'd65,
    8'd173, 8'd69,  8'd70,  8'd146, 8'd39,  8'd94,  8'd85,  8'd47,  8'd140, 8'd163, 8'd165, 8'd125, 8'd105, 8'd213, 8'd149, 8'd59,
    8'd7,   8'd88,  8'd179, 8'd64,  8'd134, 8'd172, 8'd29,  8'd247, 8'd48,  8'd55,  8'd107, 8'd228, 8'd136, 8'd217, 8'd231, 8'd137,
    8'd225, 8'd27,  8'd131, 8'd73,  8'd76,  8'd63,  8'd248, 8'd254, 8'd141, 8'd83,  8'd170, 8'd144, 8'd202, 8'd216, 8'd133, 8'd97,
    8'd32,  8'd113, 8'd103, 8'd164, 8'd45,  8'd43,  8'd9,   8'd91,  8'd203, 8'd155, 8'd37,  8'd208, 8'd190, 8'd229, 8'd108, 8'd82,
    8'd89,  8'd166, 8'd116, 8'd210, 8'd230, 8'd244, 8'd180, 8'd192, 8'd209, 8'd102, 8'd175, 8'd194, 8'd57,  8'd75,  8'd99,  8'd182
  };

  // GF(2^8) multiply modulo x^8+x^7+x^6+x+1 (0x1C3).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'hC3 : 8'h00);
    end
    return acc;
  endfunction

  // Coefficient applied to byte k (byte 15 = bits [127:120]).
  function automatic logic [7:0] lin_coef(input int k);
    case (k)
      1, 15:   return 8'd148;
      2, 14:   return 8'd32;
      3, 13:   return 8'd133;
      4, 12:   return 8'd16;
      5, 11:   return 8'd194;
      6, 10:   return 8'd192;
      8:       return 8'd251;
      default: return 8'd1;
    endcase
  endfunction

  function automatic logic [127:0] r_fn(input logic [127:0] a);
    logic [7:0] s;
    s = '0;
    for (int k = 0; k < 16; k++) s = s ^ gf_mul(a[8*k +: 8], lin_coef(k));
    return {s, a[127:8]};
  endfunction

  function automatic logic [127:0] l_fn(input logic [127:0] a);
    logic [127:0] v;
    v = a;
    for (int k = 0; k < 16; k++) v = r_fn(v);
    return v;
  endfunction

  function automatic logic [127:0] s_fn(input logic [127:0] a);
    logic [127:0] v;
    for (int k = 0; k < 16; k++) v[8*k +: 8] = PI[a[8*k +: 8]];
    return v;
  endfunction

  // Iteration constants C_i = L(Vec128(i)), folded at elaboration.
  logic [127:0] c_tab [NUM_ITER];
  for (genvar g = 0; g < NUM_ITER; g++) begin : g_const
    localparam logic [127:0] C_I = l_fn(128'(g + 1));
    assign c_tab[g] = C_I;
  end

  state_e       state;
  logic [5:0]   iter;
  logic [127:0] a1;
  logic [127:0] a0;
  logic [127:0] t;
  logic [127:0] rk [NUM_RK];
`ifndef GH_KS_UNROLL_EN
  logic [3:0]   sub;
`endif

  logic [4:0]   c_idx;
  logic [3:0]   rk_wr_idx;
  logic [127:0] lin_out;
  logic [127:0] new_a1;
  logic         lin_last;

  assign c_idx     = 5'(iter - 6'd1);
  assign rk_wr_idx = iter[5:2];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
`ifdef GH_KS_UNROLL_EN
    lin_out  = l_fn(t);
    lin_last = 1'b1;
`else
    lin_out  = r_fn(t);
    lin_last = (sub == 4'd15);
`endif
    new_a1 = lin_out ^ a0;
  end

  always_comb begin
    rk_o = '0;
    if (rk_addr_i < 4'(NUM_RK)) rk_o = rk[rk_addr_i];
  end

  // NOTE: sequential state uses non-blocking assignments only, so a0 <= a1 takes the pre-edge a1.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      busy_o  <= 1'b0;
      ready_o <= 1'b0;
      iter    <= '0;
      a1      <= '0;
      a0      <= '0;
      t       <= '0;
`ifndef GH_KS_UNROLL_EN
      sub     <= '0;
`endif
      // NOTE: the key file is flops, not RAM, so it is cleared by reset and rk_o reads 0 afterwards.
      for (int k = 0; k < NUM_RK; k++) rk[k] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (req_i) begin
            a1      <= key_i[255:128];
            a0      <= key_i[127:0];
            rk[0]   <= key_i[255:128];
            rk[1]   <= key_i[127:0];
            ready_o <= 1'b0;
            busy_o  <= 1'b1;
            iter    <= 6'd1;
            state   <= LOAD;
          end
        end
        LOAD: state <= SX;
        SX: begin
          t     <= s_fn(a1 ^ c_tab[c_idx]);
`ifndef GH_KS_UNROLL_EN
          sub   <= '0;
`endif
          state <= LIN;
        end
        LIN: begin
`ifndef GH_KS_UNROLL_EN
          t   <= lin_out;
          sub <= sub + 4'd1;
`endif
          if (lin_last) begin
            a1   <= new_a1;
            a0   <= a1;
            iter <= iter + 6'd1;
            // Every eighth Feistel iteration yields the next key pair.
            if (iter[2:0] == 3'd0) begin
              rk[rk_wr_idx]        <= new_a1;
              rk[rk_wr_idx + 4'd1] <= a1;
            end
            if (iter == 6'(NUM_ITER)) begin
              busy_o  <= 1'b0;
              ready_o <= 1'b1;
              state   <= DONE;
            end else begin
              state <= SX;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grasshopper_key_expand.sv
// Scoreboard bench for grasshopper_key_expand: stimulus queues expectations, a monitor checks them.
module tb_grasshopper_key_expand;

`ifdef GH_KS_UNROLL_EN
  localparam int LAT         = 65;
  localparam int BUSY_REQ_AT = 20;
  localparam int RST_AT      = 40;
`else
  localparam int LAT         = 545;
  localparam int BUSY_REQ_AT = 100;
  localparam int RST_AT      = 200;
`endif
  localparam int NUM_RK = 10;

  localparam logic [255:0] STD_KEY =
    256'h8899aabbccddeeff0011223344556677_fedcba98765432100123456789abcdef;
  localparam logic [127:0] STD_K1  = 128'h8899aabbccddeeff0011223344556677;
  localparam logic [127:0] STD_K2  = 128'hfedcba98765432100123456789abcdef;
  localparam logic [127:0] STD_K3  = 128'hdb31485315694343228d6aef8cc78c44;
  localparam logic [127:0] STD_K4  = 128'h3d4553d8e9cfec6815ebadc40a9ffd04;
  localparam logic [127:0] STD_K10 = 128'h72e9dd7416bcf45b755dbaa88e4a4043;

  localparam logic [1:0] M_SKIP = 2'd0;
  localparam logic [1:0] M_EQ   = 2'd1;
  localparam logic [1:0] M_NZ   = 2'd2;

  typedef enum logic {CHK_SNAP, CHK_RUN} chk_kind_e;
  typedef struct {
    chk_kind_e                 kind;
    int                        accept;
    logic [NUM_RK*128-1:0]     keys;
    logic [2*NUM_RK-1:0]       mode;
  } chk_t;

  logic         clk_i;
  logic         rst_i;
  logic         req_i;
  logic [255:0] key_i;
  logic         busy_o;
  logic         ready_o;
  logic [3:0]   rk_addr_i;
  logic [127:0] rk_o;

  chk_t q[$];
  int   cyc;
  bit   mon_active;
  int   n_cmp;
  int   n_fail;

  grasshopper_key_expand dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .key_i     (key_i),
    .busy_o    (busy_o),
    .ready_o   (ready_o),
    .rk_addr_i (rk_addr_i),
    .rk_o      (rk_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic chk_t set_slot(input chk_t it, input int a, input logic [127:0] v, input logic [1:0] m);
    chk_t r;
    r = it;
    r.keys[a*128 +: 128] = v;
    r.mode[a*2 +: 2]     = m;
    return r;
  endfunction

  function automatic chk_t snap_item();
    chk_t it;
    it.kind   = CHK_SNAP;
    it.accept = 0;
    it.keys   = '0;
    it.mode   = '0;
    return it;
  endfunction

  function automatic chk_t std_run();
    chk_t it;
    it      = snap_item();
    it.kind = CHK_RUN;
    it      = set_slot(it, 0, STD_K1,  M_EQ);
    it      = set_slot(it, 1, STD_K2,  M_EQ);
    it      = set_slot(it, 2, STD_K3,  M_EQ);
    it      = set_slot(it, 3, STD_K4,  M_EQ);
    it      = set_slot(it, 9, STD_K10, M_EQ);
    return it;
  endfunction

  function automatic chk_t zero_run();
    chk_t it;
    it      = snap_item();
    it.kind = CHK_RUN;
    it      = set_slot(it, 0, '0, M_EQ);
    it      = set_slot(it, 1, '0, M_EQ);
    it      = set_slot(it, 2, '0, M_NZ);
    it      = set_slot(it, 9, '0, M_NZ);
    return it;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp, input bit nz);
    bit ok;
    n_cmp++;
    ok = nz ? (act != '0) : (act === exp);
    if (!ok) begin
      n_fail++;
      if (nz) $display("FAIL %s: got %h, required nonzero", name, act);
      else    $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic do_snap();
    rk_addr_i = 4'd0;
    #1;
    check("snap_busy",  128'(busy_o),  128'(0), 1'b0);
    check("snap_ready", 128'(ready_o), 128'(0), 1'b0);
    for (int a = 0; a < 16; a++) begin
      rk_addr_i = 4'(a);
      #1;
      check($sformatf("snap_rk[%0d]", a), rk_o, '0, 1'b0);
    end
  endtask

  task automatic do_run(input chk_t it);
    int busy_err;
    int oob_err;
    int n;
    bit seen;
    busy_err = 0;
    oob_err  = 0;
    n        = 0;
    seen     = 1'b0;
    while (cyc < it.accept) @(negedge clk_i);
    rk_addr_i = 4'd10;
    #1;
    check("ready_drop", 128'(ready_o), 128'(0), 1'b0);
    check("busy_start", 128'(busy_o),  128'(1), 1'b0);
    while (n < LAT + 50) begin
      if (ready_o) begin
        seen = 1'b1;
        break;
      end
      if (!busy_o) busy_err++;
      if (rk_o != '0) oob_err++;
      @(negedge clk_i);
      n++;
      rk_addr_i = 4'(10 + n % 6);
      #1;
    end
    check("ready_seen", 128'(seen),             128'(1),   1'b0);
    check("latency",    128'(cyc - it.accept),  128'(LAT), 1'b0);
    check("busy_end",   128'(busy_o),           128'(0),   1'b0);
    check("busy_gaps",  128'(busy_err),         128'(0),   1'b0);
    check("oob_busy",   128'(oob_err),          128'(0),   1'b0);
    for (int a = 10; a < 16; a++) begin
      rk_addr_i = 4'(a);
      #1;
      check($sformatf("oob_done[%0d]", a), rk_o, '0, 1'b0);
    end
    for (int a = 0; a < NUM_RK; a++) begin
      if (it.mode[a*2 +: 2] != M_SKIP) begin
        rk_addr_i = 4'(a);
        #1;
        check($sformatf("rk[%0d]", a), rk_o, it.keys[a*128 +: 128], it.mode[a*2 +: 2] == M_NZ);
      end
    end
    rk_addr_i = 4'd10;
  endtask

  initial begin : monitor
    chk_t it;
    rk_addr_i  = 4'd0;
    mon_active = 1'b0;
    forever begin
      @(negedge clk_i);
      if (q.size() != 0) begin
        mon_active = 1'b1;
        it = q.pop_front();
        if (it.kind == CHK_SNAP) do_snap();
        else                     do_run(it);
        mon_active = 1'b0;
      end
    end
  end

  task automatic issue(input logic [255:0] k, input bit push, input chk_t it, output int e);
    chk_t r;
    @(negedge clk_i);
    e = cyc + 1;
    if (push) begin
      r        = it;
      r.accept = e;
      q.push_back(r);
    end
    key_i = k;
    req_i = 1'b1;
    @(negedge clk_i);
    req_i = 1'b0;
    key_i = {8{$urandom}};
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || mon_active) && n < 5000) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 5000) begin
      $display("FAIL drain_timeout: monitor busy after %0d cycles, required idle", n);
      $fatal(1, "scoreboard stuck");
    end
  endtask

  initial begin : stimulus
    int e;
    rst_i = 1'b0;
    req_i = 1'b0;
    key_i = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    q.push_back(snap_item());
    wait_drain();

    // Standard vector; an all-zero request mid-run must be ignored.
    issue(STD_KEY, 1'b1, std_run(), e);
    while (cyc < e + BUSY_REQ_AT - 1) @(negedge clk_i);
    key_i = '0;
    req_i = 1'b1;
    @(negedge clk_i);
    req_i = 1'b0;
    wait_drain();

    // Restart from DONE with an all-zero key.
    issue('0, 1'b1, zero_run(), e);
    wait_drain();

    // Abort a run with reset, then a full clean run.
    issue(STD_KEY, 1'b0, snap_item(), e);
    while (cyc < e + RST_AT - 1) @(negedge clk_i);
    rst_i = 1'b0;
    q.push_back(snap_item());
    wait_drain();
    @(negedge clk_i);
    rst_i = 1'b1;
    q.push_back(snap_item());
    wait_drain();
    issue(STD_KEY, 1'b1, std_run(), e);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
